// File: rtl/ram_sdp_arbiter.sv
// Shares one simple-dual-port RAM between NUM_PORTS requesters using independent
// round-robin read/write arbiters and a tag pipeline that routes read data home.
module ram_sdp_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             rd_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_PORTS-1:0]             rd_gnt,
  output logic [NUM_PORTS-1:0]             rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]            rd_rsp_data,
  input  logic [NUM_PORTS-1:0]             wr_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  wr_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wr_data,
  output logic [NUM_PORTS-1:0]             wr_gnt,
  output logic                             ram_rd_en,
  output logic [ADDR_WIDTH-1:0]            ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]            ram_rd_data,
  output logic                             ram_wr_en,
  output logic [ADDR_WIDTH-1:0]            ram_wr_addr,
  output logic [DATA_WIDTH-1:0]            ram_wr_data
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
    $fatal(1, "ram_sdp_arbiter: RD_LATENCY must be 1 or 2");
  end
  if ((NUM_PORTS < 2) || (NUM_PORTS > 16)) begin : g_bad_ports
    $fatal(1, "ram_sdp_arbiter: NUM_PORTS must be in 2..16");
  end

  // Returns {found, index}; the candidate closest after 'last' wins because
  // the loop walks the ring backwards and the final hit overwrites earlier ones.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                             input logic [IDX_W-1:0]     last);
    logic [IDX_W:0] res;
    int             cand;
    res = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = (int'(last) + k) % NUM_PORTS;
      if (req[cand[IDX_W-1:0]]) begin
        res = {1'b1, cand[IDX_W-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [IDX_W-1:0]      rd_last_q, rd_last_d;
  logic [IDX_W-1:0]      wr_last_q, wr_last_d;
  logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [IDX_W-1:0]      tag_idx_q [RD_LATENCY];
  logic [IDX_W-1:0]      tag_idx_d [RD_LATENCY];

  logic [IDX_W:0]   rd_pick_s, wr_pick_s;
  logic             rd_any_s, wr_any_s, inflight_s;
  logic [IDX_W-1:0] rd_idx_s, wr_idx_s;

  // Arbitration, RAM command muxing and pointer next-state.
  always_comb begin
    rd_pick_s  = rr_pick(rd_req, rd_last_q);
    wr_pick_s  = rr_pick(wr_req, wr_last_q);
    rd_any_s   = rst_n & rd_pick_s[IDX_W];
    wr_any_s   = rst_n & wr_pick_s[IDX_W];
    rd_idx_s   = rd_pick_s[IDX_W-1:0];
    wr_idx_s   = wr_pick_s[IDX_W-1:0];
    inflight_s = rst_n & (|tag_vld_q);

    rd_gnt      = '0;
    wr_gnt      = '0;
    ram_rd_addr = '0;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    if (rd_any_s) begin
      rd_gnt[rd_idx_s] = 1'b1;
      ram_rd_addr      = rd_addr[rd_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
    end else begin
      rd_gnt      = '0;
      ram_rd_addr = '0;
    end
    if (wr_any_s) begin
      wr_gnt[wr_idx_s] = 1'b1;
      ram_wr_addr      = wr_addr[wr_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
      ram_wr_data      = wr_data[wr_idx_s*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      wr_gnt      = '0;
      ram_wr_addr = '0;
      ram_wr_data = '0;
    end
    ram_wr_en = wr_any_s;
    // Keep rd_en high while tags are in flight so the RAM output register drains.
    ram_rd_en = rd_any_s | inflight_s;

    rd_last_d = rd_any_s ? rd_idx_s : rd_last_q;
    wr_last_d = wr_any_s ? wr_idx_s : wr_last_q;
  end

  // Tag pipeline next-state: advances in lock-step with the RAM read path.
  always_comb begin
    tag_vld_d = tag_vld_q;
    tag_idx_d = tag_idx_q;
    if (ram_rd_en) begin
      tag_vld_d[0] = rd_any_s;
      tag_idx_d[0] = rd_idx_s;
      for (int k = 1; k < RD_LATENCY; k++) begin
        tag_vld_d[k] = tag_vld_q[k-1];
        tag_idx_d[k] = tag_idx_q[k-1];
      end
    end else begin
      tag_vld_d = tag_vld_q;
    end
  end

  // Arbiter pointers and tag pipeline state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_last_q <= LAST_IDX;
      wr_last_q <= LAST_IDX;
      tag_vld_q <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        tag_idx_q[k] <= '0;
      end
    end else begin
      rd_last_q <= rd_last_d;
      wr_last_q <= wr_last_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
    end
  end

  // Response steering from the last pipeline stage; data is broadcast.
  always_comb begin
    rd_rsp_valid = '0;
    if (rst_n && tag_vld_q[RD_LATENCY-1]) begin
      rd_rsp_valid[tag_idx_q[RD_LATENCY-1]] = 1'b1;
    end else begin
      rd_rsp_valid = '0;
    end
    rd_rsp_data = ram_rd_data;
  end

endmodule

// File: tb/tb_ram_sdp_arbiter.sv
// Bench for ram_sdp_arbiter: a RD_LATENCY=2 / WRITE_FIRST RAM build and a
// RD_LATENCY=1 / read-first RAM build driven by identical requester traffic.
module tb_ram_sdp_arbiter;
  localparam int NP = 4;
  localparam int AW = 10;
  localparam int DW = 16;

  logic clk;
  logic rst_n;
  logic ram_clr;
  logic [NP-1:0]    rd_req, wr_req;
  logic [NP*AW-1:0] rd_addr, wr_addr;
  logic [NP*DW-1:0] wr_data;

  logic [NP-1:0] rd_gnt_a, wr_gnt_a, rd_rsp_valid_a;
  logic [DW-1:0] rd_rsp_data_a, ram_rd_data_a, ram_wr_data_a;
  logic [AW-1:0] ram_rd_addr_a, ram_wr_addr_a;
  logic          ram_rd_en_a, ram_wr_en_a;
  logic [NP-1:0] rd_gnt_b, wr_gnt_b, rd_rsp_valid_b;
  logic [DW-1:0] rd_rsp_data_b, ram_rd_data_b, ram_wr_data_b;
  logic [AW-1:0] ram_rd_addr_b, ram_wr_addr_b;
  logic          ram_rd_en_b, ram_wr_en_b;

  ram_sdp_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt_a),
    .rd_rsp_valid(rd_rsp_valid_a), .rd_rsp_data(rd_rsp_data_a), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt_a), .ram_rd_en(ram_rd_en_a),
    .ram_rd_addr(ram_rd_addr_a), .ram_rd_data(ram_rd_data_a), .ram_wr_en(ram_wr_en_a),
    .ram_wr_addr(ram_wr_addr_a), .ram_wr_data(ram_wr_data_a));

  ram_sdp_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt_b),
    .rd_rsp_valid(rd_rsp_valid_b), .rd_rsp_data(rd_rsp_data_b), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt_b), .ram_rd_en(ram_rd_en_b),
    .ram_rd_addr(ram_rd_addr_b), .ram_rd_data(ram_rd_data_b), .ram_wr_en(ram_wr_en_b),
    .ram_wr_addr(ram_wr_addr_b), .ram_wr_data(ram_wr_data_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM A: registered output (two-stage), write-first on same-address collision.
  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] a_s1, a_s2;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= '0;
    end else begin
      if (ram_wr_en_a) mem_a[ram_wr_addr_a] <= ram_wr_data_a;
      if (ram_rd_en_a) begin
        a_s1 <= (ram_wr_en_a && ram_wr_addr_a == ram_rd_addr_a) ? ram_wr_data_a : mem_a[ram_rd_addr_a];
        a_s2 <= a_s1;
      end
    end
  end
  assign ram_rd_data_a = a_s2;

  // RAM B: unregistered output (one stage), read-first on collision.
  logic [DW-1:0] mem_b [1024];
  logic [DW-1:0] b_s1;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) mem_b[i] <= '0;
    end else begin
      if (ram_wr_en_b) mem_b[ram_wr_addr_b] <= ram_wr_data_b;
      if (ram_rd_en_b) b_s1 <= mem_b[ram_rd_addr_b];
    end
  end
  assign ram_rd_data_b = b_s1;

  // ---------------- reference model ----------------
  typedef struct { int port; logic [DW-1:0] data; int due; } rsp_t;
  rsp_t qa[$];
  rsp_t qb[$];
  logic [DW-1:0] ref_mem [1024];
  int rd_last, wr_last, cyc, e_rd, e_wr;
  logic [AW-1:0] e_ra, e_wa;
  logic [DW-1:0] e_wd;
  int n_chk, n_err;

  function automatic int rr_pick(input logic [NP-1:0] req, input int last);
    for (int k = 1; k <= NP; k++) begin
      if (req[(last + k) % NP]) return (last + k) % NP;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_dut(input string t,
      input logic [NP-1:0] rg, input logic [NP-1:0] wg, input logic ren, input logic [AW-1:0] ra,
      input logic wen, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
      input logic [NP-1:0] rv, input logic [DW-1:0] rd,
      input logic [NP-1:0] x_rg, input logic [NP-1:0] x_wg, input logic x_ren,
      input logic [NP-1:0] x_rv, input logic [DW-1:0] x_rd);
    chk({t, ".rd_gnt"}, rg, x_rg);
    chk({t, ".wr_gnt"}, wg, x_wg);
    chk({t, ".ram_rd_en"}, ren, x_ren);
    chk({t, ".ram_rd_addr"}, ra, e_ra);
    chk({t, ".ram_wr_en"}, wen, |x_wg);
    chk({t, ".ram_wr_addr"}, wa, e_wa);
    chk({t, ".ram_wr_data"}, wd, e_wd);
    chk({t, ".rd_rsp_valid"}, rv, x_rv);
    if (x_rv != '0) chk({t, ".rd_rsp_data"}, rd, x_rd);
  endtask

  task automatic at_neg();
    logic [NP-1:0] g_rd, g_wr, v_a, v_b;
    logic [DW-1:0] d_a, d_b;
    logic pend_a, pend_b;
    @(negedge clk);
    e_rd = rst_n ? rr_pick(rd_req, rd_last) : -1;
    e_wr = rst_n ? rr_pick(wr_req, wr_last) : -1;
    g_rd = '0; g_wr = '0; e_ra = '0; e_wa = '0; e_wd = '0;
    if (e_rd >= 0) begin g_rd[e_rd] = 1'b1; e_ra = rd_addr[e_rd*AW +: AW]; end
    if (e_wr >= 0) begin
      g_wr[e_wr] = 1'b1; e_wa = wr_addr[e_wr*AW +: AW]; e_wd = wr_data[e_wr*DW +: DW];
    end
    pend_a = rst_n && qa.size() > 0; v_a = '0; d_a = '0;
    if (pend_a && qa[0].due == cyc) begin v_a[qa[0].port] = 1'b1; d_a = qa[0].data; void'(qa.pop_front()); end
    pend_b = rst_n && qb.size() > 0; v_b = '0; d_b = '0;
    if (pend_b && qb[0].due == cyc) begin v_b[qb[0].port] = 1'b1; d_b = qb[0].data; void'(qb.pop_front()); end
    check_dut("A", rd_gnt_a, wr_gnt_a, ram_rd_en_a, ram_rd_addr_a, ram_wr_en_a, ram_wr_addr_a,
              ram_wr_data_a, rd_rsp_valid_a, rd_rsp_data_a, g_rd, g_wr, (e_rd >= 0) || pend_a, v_a, d_a);
    check_dut("B", rd_gnt_b, wr_gnt_b, ram_rd_en_b, ram_rd_addr_b, ram_wr_en_b, ram_wr_addr_b,
              ram_wr_data_b, rd_rsp_valid_b, rd_rsp_data_b, g_rd, g_wr, (e_rd >= 0) || pend_b, v_b, d_b);
  endtask

  task automatic at_pos();
    rsp_t r;
    @(posedge clk);
    if (!rst_n) begin
      qa.delete(); qb.delete(); rd_last = NP - 1; wr_last = NP - 1;
    end else begin
      if (e_rd >= 0) begin
        r.port = e_rd;
        r.data = (e_wr >= 0 && e_wa == e_ra) ? e_wd : ref_mem[e_ra];
        r.due  = cyc + 2;
        qa.push_back(r);
        r.data = ref_mem[e_ra];
        r.due  = cyc + 1;
        qb.push_back(r);
        rd_last = e_rd;
      end
      if (e_wr >= 0) begin ref_mem[e_wa] = e_wd; wr_last = e_wr; end
    end
    cyc++;
    #1;
  endtask

  task automatic tick(); at_neg(); at_pos(); endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_req[p] = 1'b1; rd_addr[p*AW +: AW] = a;
  endtask
  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req[p] = 1'b1; wr_addr[p*AW +: AW] = a; wr_data[p*DW +: DW] = d;
  endtask

  task automatic idle_reset();
    rd_req = '0; wr_req = '0;
    repeat (3) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
  endtask

  typedef struct { bit do_reset; logic [NP-1:0] req; logic [NP-1:0] gnt; } vec_t;
  vec_t vec [14];
  logic [NP-1:0] acc;

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; rd_last = NP - 1; wr_last = NP - 1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    vec[0] = '{1'b1, 4'b1111, 4'b0001};
    for (int i = 1; i < 8; i++) vec[i] = '{1'b0, 4'b1111, 4'b0001 << (i % 4)};
    vec[8]  = '{1'b1, 4'b1010, 4'b0010};
    vec[9]  = '{1'b0, 4'b1010, 4'b1000};
    vec[10] = '{1'b0, 4'b1011, 4'b0001};
    vec[11] = '{1'b0, 4'b1011, 4'b0010};
    vec[12] = '{1'b0, 4'b1011, 4'b1000};
    vec[13] = '{1'b0, 4'b1011, 4'b0001};

    // Reset with every port requesting: grants must stay low.
    rst_n = 1'b0; ram_clr = 1'b1;
    rd_req = 4'b1111; wr_req = 4'b1111; rd_addr = '0; wr_addr = '0; wr_data = '0;
    tick(); tick();
    ram_clr = 1'b0; rd_req = '0; wr_req = '0;
    tick(); rst_n = 1'b1;

    // Single read of a freshly written word.
    set_wr(2, 10'd5, 16'hBEEF); at_neg(); chk("single.wr_gnt", wr_gnt_a, 4'b0100); at_pos();
    wr_req = '0;
    set_rd(1, 10'd5); at_neg(); chk("single.rd_gnt", rd_gnt_a, 4'b0010); at_pos();
    rd_req = '0;
    at_neg();
    chk("single.b_valid", rd_rsp_valid_b, 4'b0010); chk("single.b_data", rd_rsp_data_b, 16'hBEEF);
    chk("single.a_early", rd_rsp_valid_a, 4'b0000);
    at_pos();
    at_neg();
    chk("single.a_valid", rd_rsp_valid_a, 4'b0010); chk("single.a_data", rd_rsp_data_a, 16'hBEEF);
    at_pos();
    at_neg(); chk("single.a_after", rd_rsp_valid_a, 4'b0000); at_pos();

    // Table: fairness with all ports, then sparse requesters.
    for (int i = 0; i < 4; i++) rd_addr[i*AW +: AW] = 10'(i + 4);
    for (int i = 0; i < 14; i++) begin
      if (vec[i].do_reset) idle_reset();
      rd_req = vec[i].req;
      at_neg(); chk($sformatf("table%0d.rd_gnt", i), rd_gnt_a, vec[i].gnt); at_pos();
    end
    rd_req = '0; repeat (3) tick();

    // Latency-1 back-to-back reads of a preloaded block.
    for (int i = 0; i < 4; i++) begin
      set_wr(0, 10'(i), 16'(16'h0010 + i)); tick();
    end
    wr_req = '0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_rd(0, 10'(i)); else rd_req = '0;
      at_neg();
      if (i > 0) begin
        chk($sformatf("lat1.valid%0d", i), rd_rsp_valid_b, 4'b0001);
        chk($sformatf("lat1.data%0d", i), rd_rsp_data_b, 32'(16'h0010 + i - 1));
      end
      at_pos();
    end
    repeat (2) tick();

    // Same-address read and write in one cycle.
    set_wr(0, 10'd9, 16'h1234); set_rd(1, 10'd9);
    at_neg();
    chk("coll.a_wr_en", ram_wr_en_a, 1'b1); chk("coll.a_rd_en", ram_rd_en_a, 1'b1);
    chk("coll.b_wr_en", ram_wr_en_b, 1'b1); chk("coll.b_rd_en", ram_rd_en_b, 1'b1);
    at_pos();
    rd_req = '0; wr_req = '0;
    at_neg(); chk("coll.b_valid", rd_rsp_valid_b, 4'b0010); chk("coll.b_data", rd_rsp_data_b, 16'h0000); at_pos();
    at_neg(); chk("coll.a_valid", rd_rsp_valid_a, 4'b0010); chk("coll.a_data", rd_rsp_data_a, 16'h1234); at_pos();
    repeat (2) tick();

    // Reset while a read is in flight.
    set_rd(3, 10'd7); tick(); rd_req = '0;
    rst_n = 1'b0; acc = '0;
    at_neg(); acc = acc | rd_rsp_valid_a | rd_rsp_valid_b; at_pos();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_neg(); acc = acc | rd_rsp_valid_a | rd_rsp_valid_b; at_pos();
    end
    chk("rstmid.no_rsp", acc, 4'b0000);
    rd_req = 4'b1111;
    at_neg(); chk("rstmid.first_gnt", rd_gnt_a, 4'b0001); at_pos();
    rd_req = '0; repeat (3) tick();

    // Randomised traffic obeying the hold-until-granted handshake.
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      tick();
      for (int p = 0; p < NP; p++) begin
        if ((rd_req[p] && e_rd == p) || !rd_req[p]) begin
          rd_req[p] = ($urandom_range(0, 2) != 0);
          rd_addr[p*AW +: AW] = 10'($urandom_range(0, 15));
        end
        if ((wr_req[p] && e_wr == p) || !wr_req[p]) begin
          wr_req[p] = ($urandom_range(0, 2) == 0);
          wr_addr[p*AW +: AW] = 10'($urandom_range(0, 15));
          wr_data[p*DW +: DW] = 16'($urandom);
        end
      end
    end
    rst_n = 1'b1; rd_req = '0; wr_req = '0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
